// File: rtl/uart_bus_responder.sv
// uart_bus_responder: bus-mapped 8N1 UART (TXD/RXD/CON registers) with a level IRQ.
// Optional UART_LOOPBACK_EN adds CON[7] loop_en, which routes the internal TX line into the receiver.
`default_nettype none

module uart_bus_responder #(
  parameter int          CLK_FREQ  = 50000000,
  parameter int          BAUD      = 9600,
  parameter logic [31:0] BASE_ADDR = 32'h40000000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        rd,
  input  logic        wr,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        irq,
  output logic        tx,
  input  logic        rx
);

  localparam int CPB_RAW      = CLK_FREQ / BAUD;
  localparam int CLKS_PER_BIT = (CPB_RAW < 4) ? 4 : CPB_RAW;
  localparam int CW           = $clog2(CLKS_PER_BIT + 1);
  localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_START = 2'd1, S_DATA = 2'd2, S_STOP = 2'd3} state_t;

  state_t          tx_state_q, rx_state_q;
  logic [CW-1:0]   tx_cnt_q, rx_cnt_q;
  logic [2:0]      tx_bit_q, rx_bit_q;
  logic [7:0]      txd_q, rxd_q, rx_shift_q;
  logic            tx_q;
  logic            sync1_q, sync2_q, sync3_q;
  logic            tx_irq_en_q, rx_irq_en_q, irq_q;
  logic            tx_done_q, rx_valid_q, frame_err_q, overrun_q;
  logic            tx_done_d, rx_valid_d, frame_err_d, overrun_d;
  logic            sel_txd, sel_rxd, sel_con;
  logic            txd_wr, con_wr, con_rd, rxd_rd;
  logic            tx_busy, tx_fin, rx_good, rx_bad, rx_src, loop_en;
  logic [31:0]     con_val;
  logic            unused_wdata;

  assign sel_txd = (addr == BASE_ADDR + 32'h18);
  assign sel_rxd = (addr == BASE_ADDR + 32'h1C);
  assign sel_con = (addr == BASE_ADDR + 32'h20);
  assign txd_wr  = wr & sel_txd;
  assign con_wr  = wr & sel_con;
  assign con_rd  = rd & sel_con;
  assign rxd_rd  = rd & sel_rxd;
  assign unused_wdata = &{1'b0, wdata[31:8]};

`ifdef UART_LOOPBACK_EN
  logic loop_en_q;
  always_ff @(posedge clk) begin
    if (reset)       loop_en_q <= 1'b0;
    else if (con_wr) loop_en_q <= wdata[7];
  end
  assign loop_en = loop_en_q;
`else
  assign loop_en = 1'b0;
`endif

  assign tx      = loop_en ? 1'b1 : tx_q;
  assign rx_src  = loop_en ? tx_q : rx;
  assign irq     = irq_q;
  assign tx_busy = (tx_state_q != S_IDLE);
  assign con_val = {24'b0, loop_en, overrun_q, frame_err_q, tx_busy,
                    rx_valid_q, tx_done_q, rx_irq_en_q, tx_irq_en_q};

  always_comb begin
    rdata = '0;
    if (rd) begin
      if (sel_txd)      rdata = {24'b0, txd_q};
      else if (sel_rxd) rdata = {24'b0, rxd_q};
      else if (sel_con) rdata = con_val;
    end
  end

  // Flag sets take priority over same-cycle clearing reads.
  assign tx_fin  = (tx_state_q == S_STOP) && (tx_cnt_q == BIT_LAST);
  assign rx_good = (rx_state_q == S_STOP) && (rx_cnt_q == BIT_LAST) && sync2_q;
  assign rx_bad  = (rx_state_q == S_STOP) && (rx_cnt_q == BIT_LAST) && !sync2_q;

  always_comb begin
    tx_done_d   = tx_fin | (tx_done_q & ~con_rd);
    rx_valid_d  = rx_good | (rx_valid_q & ~rxd_rd);
    frame_err_d = rx_bad | (frame_err_q & ~con_rd);
    overrun_d   = (rx_good & rx_valid_q & ~rxd_rd) | (overrun_q & ~con_rd);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      tx_irq_en_q <= 1'b0;
      rx_irq_en_q <= 1'b0;
      tx_done_q   <= 1'b0;
      rx_valid_q  <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
      irq_q       <= 1'b0;
    end else begin
      if (con_wr) begin
        tx_irq_en_q <= wdata[0];
        rx_irq_en_q <= wdata[1];
      end
      tx_done_q   <= tx_done_d;
      rx_valid_q  <= rx_valid_d;
      frame_err_q <= frame_err_d;
      overrun_q   <= overrun_d;
      irq_q       <= (tx_irq_en_q & tx_done_q) | (rx_irq_en_q & rx_valid_q);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      tx_state_q <= S_IDLE;
      tx_cnt_q   <= '0;
      tx_bit_q   <= '0;
      txd_q      <= '0;
      tx_q       <= 1'b1;
    end else begin
      case (tx_state_q)
        S_IDLE: if (txd_wr) begin
          txd_q      <= wdata[7:0];
          tx_q       <= 1'b0;
          tx_cnt_q   <= '0;
          tx_state_q <= S_START;
        end
        S_START: if (tx_cnt_q == BIT_LAST) begin
          tx_cnt_q   <= '0;
          tx_bit_q   <= '0;
          tx_q       <= txd_q[0];
          tx_state_q <= S_DATA;
        end else tx_cnt_q <= tx_cnt_q + 1'b1;
        S_DATA: if (tx_cnt_q == BIT_LAST) begin
          tx_cnt_q <= '0;
          if (tx_bit_q == 3'd7) begin
            tx_q       <= 1'b1;
            tx_state_q <= S_STOP;
          end else begin
            tx_bit_q <= tx_bit_q + 3'd1;
            tx_q     <= txd_q[tx_bit_q + 3'd1];
          end
        end else tx_cnt_q <= tx_cnt_q + 1'b1;
        S_STOP: if (tx_cnt_q == BIT_LAST) begin
          tx_cnt_q   <= '0;
          tx_state_q <= S_IDLE;
        end else tx_cnt_q <= tx_cnt_q + 1'b1;
        default: tx_state_q <= S_IDLE;
      endcase
    end
  end

  // sync3_q holds the previous synchronized level for falling-edge detection.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q    <= 1'b1;
      sync2_q    <= 1'b1;
      sync3_q    <= 1'b1;
      rx_state_q <= S_IDLE;
      rx_cnt_q   <= '0;
      rx_bit_q   <= '0;
      rx_shift_q <= '0;
      rxd_q      <= '0;
    end else begin
      sync1_q <= rx_src;
      sync2_q <= sync1_q;
      sync3_q <= sync2_q;
      case (rx_state_q)
        S_IDLE: if (sync3_q && !sync2_q) begin
          rx_cnt_q   <= '0;
          rx_state_q <= S_START;
        end
        S_START: if (rx_cnt_q == HALF_LAST) begin
          rx_cnt_q   <= '0;
          rx_bit_q   <= '0;
          rx_state_q <= sync2_q ? S_IDLE : S_DATA;
        end else rx_cnt_q <= rx_cnt_q + 1'b1;
        S_DATA: if (rx_cnt_q == BIT_LAST) begin
          rx_cnt_q   <= '0;
          rx_shift_q <= {sync2_q, rx_shift_q[7:1]};
          rx_bit_q   <= rx_bit_q + 3'd1;
          if (rx_bit_q == 3'd7) rx_state_q <= S_STOP;
        end else rx_cnt_q <= rx_cnt_q + 1'b1;
        S_STOP: if (rx_cnt_q == BIT_LAST) begin
          rx_cnt_q   <= '0;
          if (sync2_q) rxd_q <= rx_shift_q;
          rx_state_q <= S_IDLE;
        end else rx_cnt_q <= rx_cnt_q + 1'b1;
        default: rx_state_q <= S_IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_uart_bus_responder.sv
// Directed bench for uart_bus_responder with TX/RX byte scoreboards (16 clocks per bit).
`default_nettype none

module tb_uart_bus_responder;
  localparam int          CPB  = 16;
  localparam logic [31:0] BASE = 32'h40000000;
  localparam logic [31:0] TXD  = BASE + 32'h18;
  localparam logic [31:0] RXD  = BASE + 32'h1C;
  localparam logic [31:0] CON  = BASE + 32'h20;

  logic        clk = 1'b0, reset = 1'b1, rd = 1'b0, wr = 1'b0, rx = 1'b1;
  logic [31:0] addr = '0, wdata = '0;
  logic [31:0] rdata;
  logic        irq, tx;

  int checks = 0;
  int errors = 0;
  logic [7:0]  tx_sb[$];
  logic [7:0]  rx_sb[$];
  logic [31:0] v;

  uart_bus_responder #(.CLK_FREQ(160), .BAUD(10), .BASE_ADDR(BASE)) dut (
    .clk(clk), .reset(reset), .rd(rd), .wr(wr), .addr(addr), .wdata(wdata),
    .rdata(rdata), .irq(irq), .tx(tx), .rx(rx)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    wr = 1'b1; addr = a; wdata = d;
    @(negedge clk);
    wr = 1'b0;
  endtask

  task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
    @(negedge clk);
    rd = 1'b1; addr = a;
    #1 d = rdata;
    @(negedge clk);
    rd = 1'b0;
  endtask

  // Called on the first negedge after the TXD write edge; checks every cycle of the frame.
  task automatic check_tx_frame();
    logic [7:0] b;
    logic       e;
    if (tx_sb.size() == 0) begin
      check("tx_sb_empty", 32'd1, 32'd0);
      return;
    end
    b = tx_sb.pop_front();
    for (int i = 0; i < 10 * CPB; i++) begin
      if (i > 0) @(negedge clk);
      if (i < CPB) e = 1'b0;
      else if (i < 9 * CPB) e = b[(i - CPB) / CPB];
      else e = 1'b1;
      check($sformatf("tx_bit_cyc%0d", i), {31'b0, tx}, {31'b0, e});
    end
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop);
    logic [9:0] f;
    f = {stop, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      rx = f[i];
      repeat (CPB - 1) @(negedge clk);
    end
    @(negedge clk);
    rx = 1'b1;
  endtask

  task automatic read_rxd_check(input string tag);
    logic [7:0] e;
    while (rx_sb.size() > 1) void'(rx_sb.pop_front());
    if (rx_sb.size() == 0) begin
      check("rx_sb_empty", 32'd1, 32'd0);
      return;
    end
    e = rx_sb.pop_front();
    bus_read(RXD, v);
    check(tag, v, {24'b0, e});
  endtask

  initial begin
    int lows;
    logic seen;
    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_tx", {31'b0, tx}, 32'd1);
    check("rst_irq", {31'b0, irq}, 32'd0);
    reset = 1'b0;
    bus_read(CON, v); check("rst_con", v, 32'h0);
    bus_read(TXD, v); check("rst_txd", v, 32'h0);
    bus_read(RXD, v); check("rst_rxd", v, 32'h0);
    bus_read(BASE + 32'h24, v); check("unmapped_rd", v, 32'h0);

    // 1: transmit 0x5A
    tx_sb.push_back(8'h5A);
    bus_write(TXD, 32'h5A);
    check_tx_frame();
    bus_read(CON, v); check("t1_con_done", v, 32'h04);
    bus_read(CON, v); check("t1_con_cleared", v, 32'h00);
    bus_read(TXD, v); check("t1_txd", v, 32'h5A);

    // 2: receive 0xA5 with rx irq enabled; irq lags rx_valid by one cycle
    bus_write(CON, 32'h02);
    rx_sb.push_back(8'hA5);
    fork
      send_frame(8'hA5, 1'b1);
      begin
        seen = 1'b0;
        @(negedge clk);
        rd = 1'b1; addr = CON;
        for (int i = 0; i < 400 && !seen; i++) begin
          @(negedge clk);
          #1 if (rdata[3]) seen = 1'b1;
        end
        check("t2_rxvalid_seen", {31'b0, seen}, 32'd1);
        check("t2_irq_same_cycle", {31'b0, irq}, 32'd0);
        @(negedge clk);
        check("t2_irq_next_cycle", {31'b0, irq}, 32'd1);
        rd = 1'b0;
      end
    join
    read_rxd_check("t2_rxd");
    check("t2_irq_still_high", {31'b0, irq}, 32'd1);
    @(negedge clk);
    check("t2_irq_fell", {31'b0, irq}, 32'd0);
    bus_read(CON, v); check("t2_con_after_read", v, 32'h02);
    bus_write(CON, 32'h00);

    // 3: two frames without reading -> overrun
    rx_sb.push_back(8'h11); send_frame(8'h11, 1'b1);
    rx_sb.push_back(8'h22); send_frame(8'h22, 1'b1);
    repeat (4) @(negedge clk);
    bus_read(CON, v); check("t3_con_overrun", v, 32'h48);
    bus_read(CON, v); check("t3_con_ovr_clr", v, 32'h08);
    read_rxd_check("t3_rxd");

    // 4: framing error, then a short glitch, then a clean frame
    send_frame(8'h33, 1'b0);
    repeat (4) @(negedge clk);
    bus_read(CON, v); check("t4_con_ferr", v, 32'h20);
    bus_read(RXD, v); check("t4_rxd_unchanged", v, 32'h22);
    bus_read(CON, v); check("t4_con_ferr_clr", v, 32'h00);
    @(negedge clk); rx = 1'b0;
    repeat (4) @(negedge clk); rx = 1'b1;
    repeat (40) @(negedge clk);
    bus_read(CON, v); check("t4_glitch_con", v, 32'h00);
    rx_sb.push_back(8'h5C); send_frame(8'h5C, 1'b1);
    repeat (4) @(negedge clk);
    bus_read(CON, v); check("t4_after_glitch_con", v, 32'h08);
    read_rxd_check("t4_after_glitch_rxd");

    // 5: write while busy is ignored
    tx_sb.push_back(8'h01);
    bus_write(TXD, 32'h01);
    fork
      check_tx_frame();
      begin
        repeat (50) @(negedge clk);
        bus_write(TXD, 32'hFF);
      end
    join
    bus_read(TXD, v); check("t5_txd_kept", v, 32'h01);
    bus_read(CON, v); check("t5_con_done", v, 32'h04);
    lows = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (tx !== 1'b1) lows++;
    end
    check("t5_no_second_frame", lows, 32'd0);

    // Reset mid-frame
    bus_write(TXD, 32'h00);
    repeat (30) @(negedge clk);
    check("t5_tx_low_midframe", {31'b0, tx}, 32'd0);
    reset = 1'b1;
    @(negedge clk);
    check("t5_tx_after_reset", {31'b0, tx}, 32'd1);
    check("t5_irq_after_reset", {31'b0, irq}, 32'd0);
    reset = 1'b0;
    bus_read(CON, v); check("t5_con_after_reset", v, 32'h00);
    bus_read(RXD, v); check("t5_rxd_after_reset", v, 32'h00);
    bus_read(TXD, v); check("t5_txd_after_reset", v, 32'h00);
    rx_sb.delete();

`ifdef UART_LOOPBACK_EN
    // 6: internal loopback
    bus_write(CON, 32'h80);
    rx_sb.push_back(8'hC3);
    bus_write(TXD, 32'hC3);
    lows = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (tx !== 1'b1) lows++;
    end
    check("t6_tx_pin_idle", lows, 32'd0);
    bus_read(CON, v); check("t6_con", v, 32'h8C);
    read_rxd_check("t6_rxd");
`else
    bus_write(CON, 32'h83);
    bus_read(CON, v); check("t6_con_bit7_ro", v, 32'h03);
    bus_write(CON, 32'h00);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

`default_nettype wire
